// File: rtl/vecseq_pkg.sv
// Shared types and LFSR tap table for the vector sequencer.
// Tap masks give maximal-length Fibonacci sequences for widths 2..16.
package vecseq_pkg;

    // RUN and DONE each own one bit, so vec_valid/busy/done come straight off a flop.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    function automatic logic [15:0] lfsr_taps(input int unsigned w);
        logic [15:0] t;
        case (w)
            2:       t = 16'b0000_0000_0000_0011;
            3:       t = 16'b0000_0000_0000_0110;
            4:       t = 16'b0000_0000_0000_1100;
            5:       t = 16'b0000_0000_0001_0100;
            6:       t = 16'b0000_0000_0011_0000;
            7:       t = 16'b0000_0000_0110_0000;
            8:       t = 16'b0000_0000_1011_1000;
            9:       t = 16'b0000_0001_0001_0000;
            10:      t = 16'b0000_0010_0100_0000;
            11:      t = 16'b0000_0101_0000_0000;
            12:      t = 16'b0000_1000_0010_1001;
            13:      t = 16'b0001_0000_0000_1101;
            14:      t = 16'b0010_0000_0001_0101;
            15:      t = 16'b0110_0000_0000_0000;
            16:      t = 16'b1101_0000_0000_1000;
            default: t = 16'b0000_0000_0000_0110;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/vecseq_next.sv
// Next-vector logic: counter increment (mode=0) or Fibonacci LFSR shift (mode=1).
module vecseq_next
    import vecseq_pkg::*;
#(
    parameter int INPUT_WIDTH = 3
) (
    input  logic [INPUT_WIDTH-1:0] cur,
    input  logic                   mode,
    output logic [INPUT_WIDTH-1:0] nxt
);

    localparam logic [15:0]            TAPS_ALL = lfsr_taps(INPUT_WIDTH);
    localparam logic [INPUT_WIDTH-1:0] TAPS     = TAPS_ALL[INPUT_WIDTH-1:0];

    always_comb begin
        nxt = cur + INPUT_WIDTH'(1);
        if (mode) begin
            nxt = {cur[INPUT_WIDTH-2:0], ^(cur & TAPS)};
        end
    end

endmodule

// File: rtl/vector_sequencer.sv
// Stimulus generator: emits NUMBER_OF_TESTS vectors over a valid/ready port.
// Handshake: a vector transfers on a rising edge where vec_valid & vec_ready; vec/vec_index hold otherwise.
module vector_sequencer
    import vecseq_pkg::*;
#(
    parameter int INPUT_WIDTH     = 3,
    parameter int NUMBER_OF_TESTS = 8,
    parameter int IDX_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   mode,
    input  logic [INPUT_WIDTH-1:0] seed,
    output logic                   vec_valid,
    input  logic                   vec_ready,
    output logic [INPUT_WIDTH-1:0] vec,
    output logic [IDX_WIDTH-1:0]   vec_index,
    output logic                   busy,
    output logic                   done,
    output state_e                 state_dbg
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUMBER_OF_TESTS - 1);

    state_e                 state_q, state_d;
    logic [INPUT_WIDTH-1:0] vec_q, vec_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   mode_q, mode_d;
    logic [INPUT_WIDTH-1:0] vec_nxt;
    logic [INPUT_WIDTH-1:0] load_vec;

    vecseq_next #(
        .INPUT_WIDTH(INPUT_WIDTH)
    ) u_next (
        .cur (vec_q),
        .mode(mode_q),
        .nxt (vec_nxt)
    );

    // An all-zero LFSR seed would lock up, so it is promoted to 1.
    assign load_vec = (mode && (seed == '0)) ? INPUT_WIDTH'(1) : seed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= '0;
            idx_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            idx_q   <= idx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        idx_d   = idx_q;
        mode_d  = mode_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d = RUN;
                        vec_d   = load_vec;
                        idx_d   = '0;
                        mode_d  = mode;
                    end
                end
                RUN: begin
                    if (vec_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                        end else begin
                            vec_d = vec_nxt;
                            idx_d = idx_q + IDX_WIDTH'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign vec_valid = state_q[0];
    assign busy      = state_q[0];
    assign done      = state_q[1];
    assign vec       = vec_q;
    assign vec_index = idx_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Directed bench for vector_sequencer (W=3, N=8) plus an N=1 instance for the single-vector case.
module tb_vector_sequencer;
  import vecseq_pkg::*;

  localparam int W = 3;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] seed = '0;
  logic         vec_ready = 1'b0;

  logic         vec_valid, busy, done;
  logic [W-1:0] vec;
  logic [15:0]  vec_index;
  state_e       state_dbg;

  logic         v1_valid, v1_busy, v1_done;
  logic [W-1:0] v1_vec;
  logic [15:0]  v1_index;
  state_e       v1_state;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  vector_sequencer #(.INPUT_WIDTH(W), .NUMBER_OF_TESTS(N), .IDX_WIDTH(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec(vec), .vec_index(vec_index),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  vector_sequencer #(.INPUT_WIDTH(W), .NUMBER_OF_TESTS(1), .IDX_WIDTH(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .vec_valid(v1_valid), .vec_ready(vec_ready), .vec(v1_vec), .vec_index(v1_index),
    .busy(v1_busy), .done(v1_done), .state_dbg(v1_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_exp(input logic [W-1:0] s0, s1, s2, s3, s4, s5, s6, s7);
    exp_q = {s0, s1, s2, s3, s4, s5, s6, s7};
  endtask

  // Pulses start for one cycle; returns at the negedge after the load edge.
  task automatic begin_run(input logic m, input logic [W-1:0] s);
    @(negedge clk);
    start = 1'b1;
    mode = m;
    seed = s;
    vec_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes exp_q; optional stall at stall_idx and a stray start at poke_idx.
  task automatic run_vectors(input string tag, input int stall_idx, input int stall_n, input int poke_idx);
    int exp_idx = 0;
    int stalls = 0;
    int budget = 0;
    int hs = 0;
    int total = exp_q.size();
    logic [W-1:0] last = '0;
    while (exp_q.size() > 0 && budget < 100) begin
      check({tag, " valid"}, 32'(vec_valid), 32'd1);
      check({tag, " vec"}, 32'(vec), 32'(exp_q[0]));
      check({tag, " index"}, 32'(vec_index), 32'(exp_idx));
      if (exp_idx == stall_idx && stalls < stall_n) begin
        vec_ready = 1'b0;
        stalls++;
      end else begin
        vec_ready = 1'b1;
        last = exp_q.pop_front();
        exp_idx++;
        hs++;
      end
      if (exp_idx == poke_idx) begin
        start = 1'b1;
        seed = 3'b101;
      end
      @(negedge clk);
      start = 1'b0;
      budget++;
    end
    vec_ready = 1'b0;
    check({tag, " no_timeout"}, 32'(budget < 100), 32'd1);
    check({tag, " handshakes"}, 32'(hs), 32'(total));
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " valid_low"}, 32'(vec_valid), 32'd0);
    check({tag, " busy_low"}, 32'(busy), 32'd0);
    check({tag, " vec_hold"}, 32'(vec), 32'(last));
    check({tag, " index_hold"}, 32'(vec_index), 32'(N - 1));
    @(negedge clk);
    check({tag, " still_done"}, 32'(done), 32'd1);
    check({tag, " still_hold"}, 32'(vec), 32'(last));
  endtask

  initial begin
    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst valid", 32'(vec_valid), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst vec", 32'(vec), 32'd0);
    check("rst index", 32'(vec_index), 32'd0);
    check("rst state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    vec_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("idle ready_no_effect", 32'(vec_valid), 32'd0);
    check("idle index", 32'(vec_index), 32'd0);

    // counter sweep
    load_exp(3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111);
    begin_run(1'b0, 3'b000);
    run_vectors("cnt", -1, 0, -1);

    // LFSR run, restarted from DONE
    load_exp(3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001);
    begin_run(1'b1, 3'b001);
    run_vectors("lfsr", -1, 0, -1);

    // backpressure at index 2, stray start at index 3 must be ignored
    load_exp(3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011);
    begin_run(1'b0, 3'b100);
    run_vectors("bp", 2, 3, 3);

    // zero-seed LFSR
    load_exp(3'b001, 3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001);
    begin_run(1'b1, 3'b000);
    run_vectors("lfsr0", -1, 0, -1);

    // abort colliding with start and a handshake at index 4
    begin_run(1'b0, 3'b010);
    for (int i = 0; i < 4; i++) begin
      vec_ready = 1'b1;
      @(negedge clk);
    end
    check("abort pre index", 32'(vec_index), 32'd4);
    abort = 1'b1;
    start = 1'b1;
    seed = 3'b111;
    vec_ready = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    check("abort valid", 32'(vec_valid), 32'd0);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort state", 32'(state_dbg), 32'(IDLE));
    @(negedge clk);
    check("abort stays_idle", 32'(vec_valid), 32'd0);
    load_exp(3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001);
    begin_run(1'b0, 3'b010);
    run_vectors("restart", -1, 0, -1);

    // reset mid-run at index 5
    begin_run(1'b1, 3'b001);
    for (int i = 0; i < 5; i++) begin
      vec_ready = 1'b1;
      @(negedge clk);
    end
    check("mrst pre index", 32'(vec_index), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    check("mrst valid", 32'(vec_valid), 32'd0);
    check("mrst busy", 32'(busy), 32'd0);
    check("mrst done", 32'(done), 32'd0);
    check("mrst vec", 32'(vec), 32'd0);
    check("mrst index", 32'(vec_index), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) @(negedge clk);
    check("mrst post valid", 32'(vec_valid), 32'd0);
    check("mrst post state", 32'(state_dbg), 32'(IDLE));

    // single-vector run on the N=1 instance
    begin_run(1'b0, 3'b110);
    check("n1 valid", 32'(v1_valid), 32'd1);
    check("n1 vec", 32'(v1_vec), 32'b110);
    check("n1 index", 32'(v1_index), 32'd0);
    vec_ready = 1'b1;
    @(negedge clk);
    vec_ready = 1'b0;
    check("n1 done", 32'(v1_done), 32'd1);
    check("n1 valid_low", 32'(v1_valid), 32'd0);
    check("n1 vec_hold", 32'(v1_vec), 32'b110);
    check("n1 index_hold", 32'(v1_index), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_sequencer.md
VECTOR_SEQUENCER -- requirements
Module: vector_sequencer

Interface
REQ-001 Parameter INPUT_WIDTH, default 3, SHALL set the vector width; supported range 2..16.
REQ-002 Parameter NUMBER_OF_TESTS, default 8, SHALL set the number of vectors per run; supported range 1..65535.
REQ-003 Parameter IDX_WIDTH, default 16, SHALL set the index width; it SHALL be at least clog2(NUMBER_OF_TESTS).
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 start  input  1  one-cycle run request.
REQ-008 abort  input  1  synchronous run cancel.
REQ-009 mode  input  1  0 = exhaustive counter, 1 = LFSR.
REQ-010 seed  input  INPUT_WIDTH  first vector; sampled on an accepted start.
REQ-011 vec_valid  output  1  vec is presented.
REQ-012 vec_ready  input  1  consumer (DUT drive stage) accepts vec.
REQ-013 vec  output  INPUT_WIDTH  stimulus vector driving the DUT inputs.
REQ-014 vec_index  output  IDX_WIDTH  ordinal of the current vector, starting at 0.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-018 IDLE->RUN SHALL occur on start=1; on that edge the block SHALL load seed into vec and 0 into vec_index, and mode SHALL be latched for the whole run.
REQ-019 In RUN, vec_valid SHALL be 1 and vec/vec_index SHALL hold stable until a handshake (vec_valid & vec_ready on a rising edge).
REQ-020 On each handshake with vec_index < NUMBER_OF_TESTS-1, vec SHALL advance on the same edge and vec_index SHALL increment.
- Zero bubbles: back-to-back handshakes SHALL be accepted every cycle.
REQ-021 Counter mode SHALL advance vec to vec+1 modulo 2^INPUT_WIDTH (wraps when NUMBER_OF_TESTS > 2^INPUT_WIDTH).
REQ-022 LFSR mode SHALL advance vec to {vec[W-2:0], ^(vec & TAPS[W])}, a Fibonacci maximal-length LFSR.
REQ-023 In LFSR mode an all-zero seed SHALL be replaced by 1 at load time, so the LFSR never locks up.
REQ-024 The handshake with vec_index = NUMBER_OF_TESTS-1 SHALL move the FSM RUN->DONE; vec_valid SHALL be 0 from the next cycle.
REQ-025 In DONE, done SHALL be 1 and vec/vec_index SHALL hold their last values.
REQ-026 DONE->RUN SHALL occur on start=1 and SHALL reload exactly as in REQ-018.
REQ-027 start SHALL be ignored in RUN.
REQ-028 abort=1 SHALL force IDLE on the next edge from any state, with vec_valid=0; abort SHALL take priority over start and over a simultaneous handshake.
REQ-029 vec_ready while vec_valid=0 SHALL have no effect.
REQ-030 With NUMBER_OF_TESTS=1, the first handshake SHALL go directly to DONE.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force the following, with no glitch on vec_valid:
- state IDLE, vec=0, vec_index=0;
- vec_valid=0, busy=0, done=0.
REQ-032 Reset asserted mid-run SHALL discard the run; after deassertion the block SHALL wait in IDLE for start.
REQ-033 All flops SHALL be reset; the block SHALL contain no uninitialised state.

Structure
REQ-034 A shared package vecseq_pkg SHALL hold:
- the state enum {IDLE, RUN, DONE};
- the TAPS table for widths 2..16 (e.g. W=3 -> 3'b110, W=4 -> 4'b1100).
REQ-035 LFSR/counter next-state logic SHALL live in one sub-module, vecseq_next.
- Combinational, parameterised by INPUT_WIDTH.
- Inputs: cur, mode. Output: nxt.

Verification
REQ-036 Counter sweep: W=3, N=8, mode=0, seed=000, vec_ready=1 -> vec 000,001,...,111 on 8 consecutive cycles, then done=1 and vec_valid=0.
REQ-037 LFSR run: W=3, N=8, mode=1, seed=001 -> vec 001,010,101,011,111,110,100,001, then done=1.
REQ-038 Backpressure: vec_ready low for 3 cycles at index 2 -> vec and vec_index stay at value/index 2 for 3 cycles; total 8 handshakes, no vector skipped or repeated.
REQ-039 Abort/start collision: abort=1 together with start and a handshake at index 4 -> next cycle IDLE, vec_valid=0, busy=0; a later start restarts from seed with index 0.
REQ-040 Reset mid-run at index 5 -> all outputs 0 asynchronously; no vec_valid until a new start.
REQ-041 Zero seed, LFSR mode: seed=000, mode=1 -> first vec=001, and the sequence matches REQ-037.
